// File: rtl/sram_burst_reader.sv
// -----------------------------------------------------------------------------
// sram_burst_reader
//
// Reads a burst of consecutive words from a synchronous-read SRAM and streams
// them out over a valid/ready interface. A 2-entry skid FIFO absorbs the one
// cycle SRAM read latency so that the stream can run at one word per cycle
// while never losing a word when the consumer stalls.
//
// Parameters
//   ADDR_WIDTH   SRAM word-address width (burst length 0..2^ADDR_WIDTH)
//   DATA_WIDTH   SRAM word width
//
// Ports
//   clk           in   sole clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   start         in   one-cycle burst request, sampled only while idle
//   base_addr     in   first SRAM address of the burst (sampled with start)
//   len           in   number of words in the burst (sampled with start)
//   busy          out  high from the accepted start until done
//   done          out  one-cycle pulse after the final word is accepted
//   sram_chip_en  out  SRAM chip enable, identical to sram_ren
//   sram_ren      out  SRAM read strobe
//   sram_raddr    out  SRAM read address
//   sram_dout     in   SRAM read data, valid the cycle after sram_ren
//   out_data      out  stream data (0 while out_valid is low)
//   out_valid     out  stream valid
//   out_ready     in   stream ready from the consumer
//   out_last      out  only with SRAM_BURST_READER_LAST_EN defined: high with
//                      the final word of a burst
//
// Optional feature macro: SRAM_BURST_READER_LAST_EN (adds out_last).
//
// Latency: the start accepted on rising edge E0 produces out_valid after the
// edge E2; with out_ready held high a new word follows on every cycle.
// -----------------------------------------------------------------------------
module sram_burst_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_chip_en,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef SRAM_BURST_READER_LAST_EN
    ,
    output logic                  out_last
`endif
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;     // next address to read
    logic [ADDR_WIDTH:0]   len_q,      len_d;      // latched burst length
    logic [ADDR_WIDTH:0]   issued_q,   issued_d;   // reads issued so far
    logic [ADDR_WIDTH:0]   popped_q,   popped_d;   // words transferred so far
    logic                  inflight_q, inflight_d; // read issued last cycle
    logic                  done_q,     done_d;

    // Two-entry FIFO between the SRAM read port and the stream output.
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q,  count_d;

    // -------------------------------------------------------------------------
    // Handshake and read-issue decisions
    // -------------------------------------------------------------------------
    logic       fifo_push;
    logic       fifo_pop;
    logic [2:0] occ_after_pop;
    logic       issue;
    logic       last_issue;
    logic       last_pop;

    // A read issued last cycle delivers its data this cycle, so it is written
    // into the FIFO at the coming edge.
    assign fifo_push = inflight_q;
    assign fifo_pop  = (count_q != 2'd0) && out_ready;

    // Words that will still occupy the pipeline after this cycle's transfer.
    // Counting the pop of this cycle is what allows back-to-back reads while
    // the consumer keeps up; the bound of 2 guarantees the FIFO never overflows
    // since every in-flight read has a guaranteed slot.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, fifo_pop};

    assign issue      = (state_q == ST_READ) && (issued_q != len_q) && (occ_after_pop < 3'd2);
    assign last_issue = issue && (issued_q == (len_q - CNT_ONE));
    assign last_pop   = fifo_pop && (popped_q == (len_q - CNT_ONE));

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // block leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        popped_d   = popped_q;
        inflight_d = issue;
        done_d     = 1'b0;

        if (fifo_pop) begin
            popped_d = popped_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        // Empty burst: acknowledge without touching the SRAM.
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_READ;
                        addr_d   = base_addr;
                        len_d    = len;
                        issued_d = '0;
                        popped_d = '0;
                    end
                end
            end

            ST_READ: begin
                if (issue) begin
                    // Address wraps naturally modulo 2^ADDR_WIDTH.
                    addr_d   = addr_q + ADDR_ONE;
                    issued_d = issued_q + CNT_ONE;
                end
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // The last word always arrives at least two cycles after its
                // read was issued, so the final transfer is only seen here.
                if (last_pop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy update; push and pop in the same cycle leave
    // the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fifo_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (fifo_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            popped_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            popped_q   <= popped_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; an entry is only ever
    // observed after it has been written, and out_data is forced to 0 while
    // the FIFO is empty, so reset needs to clear only pointers and count.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr_q] <= sram_dout;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign sram_ren     = issue;
    assign sram_chip_en = issue;
    assign sram_raddr   = addr_q;
    assign out_valid    = (count_q != 2'd0);
    assign out_data     = out_valid ? fifo_mem[rd_ptr_q] : '0;

`ifdef SRAM_BURST_READER_LAST_EN
    // popped_q counts words already transferred, so the head is the final
    // word exactly when one word of the burst remains.
    assign out_last = out_valid && (popped_q == (len_q - CNT_ONE));
`endif

endmodule

// File: doc/sram_burst_reader.md
SRAM_BURST_READER -- requirements
Module: sram_burst_reader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning SRAM word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first SRAM address of burst, sampled with start.
REQ-007 SHALL have port len  input  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, sampled with start.
REQ-008 SHALL have port busy  output  1  high from accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after final word is accepted downstream.
REQ-010 SHALL have port sram_chip_en  output  1  SRAM chip enable; high exactly when sram_ren is high.
REQ-011 SHALL have port sram_ren  output  1  SRAM read strobe.
REQ-012 SHALL have port sram_raddr  output  ADDR_WIDTH  SRAM read address.
REQ-013 SHALL have port sram_dout  input  DATA_WIDTH  SRAM read data, valid the cycle after sram_ren.
REQ-014 SHALL have port out_data  output  DATA_WIDTH  stream data.
REQ-015 SHALL have port out_valid  output  1  stream valid.
REQ-016 SHALL have port out_ready  input  1  stream ready from consumer.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE; busy high in READ and DRAIN.
REQ-018 SHALL in IDLE on start with len!=0 latch base_addr/len, enter READ; start with len==0 SHALL pulse done next cycle and stay IDLE.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL in READ assert sram_ren only when (reads in flight + buffered words) < 2; each issue increments sram_raddr by 1, wrapping modulo 2^ADDR_WIDTH.
REQ-021 SHALL capture sram_dout exactly one cycle after each sram_ren into a 2-entry FIFO; no captured word is ever dropped.
REQ-022 SHALL present FIFO head on out_data with out_valid=1 when non-empty; transfer occurs when out_valid & out_ready.
REQ-023 SHALL hold out_data and out_valid stable while out_valid & !out_ready.
REQ-024 SHALL move READ -> DRAIN in the cycle after the len-th read is issued; DRAIN -> IDLE when the len-th word transfers, with done pulsing that same transition cycle+1 and busy dropping with it.
REQ-025 SHALL sustain one word per cycle when out_ready is held high (first out_valid 2 cycles after start).
REQ-026 SHALL allow simultaneous FIFO push and pop in one cycle, count unchanged.
REQ-027 SHALL emit words in address order base_addr, base_addr+1, ... modulo 2^ADDR_WIDTH.

Reset
REQ-028 SHALL on rst_n low immediately force: FSM IDLE, FIFO empty, in-flight count 0, busy=0, done=0, sram_ren=0, sram_chip_en=0, sram_raddr=0, out_valid=0, out_data=0.
REQ-029 SHALL abandon any burst when reset asserts mid-operation; no done pulse for it.

Configuration
REQ-030 SHALL, with macro SRAM_BURST_READER_LAST_EN defined, add output out_last (1 bit) high with the final word of a burst and 0 otherwise (reset 0).
REQ-031 SHALL, without SRAM_BURST_READER_LAST_EN, have no out_last port and otherwise identical behaviour.

Verification
REQ-032 SHALL test: mem[i]=i+100, start base=2 len=4, out_ready=1 -> out_data 102,103,104,105 on consecutive cycles, done one pulse.
REQ-033 SHALL test: base=14 len=4 -> addresses 14,15,0,1, data 114,115,100,101.
REQ-034 SHALL test: len=4, out_ready toggling 1,0,0,1,... -> no loss/duplication, data stable while stalled, at most 2 in flight+buffered.
REQ-035 SHALL test: len=0 -> no sram_ren, done one pulse, busy stays 0; start during busy ignored.
REQ-036 SHALL test: rst_n low after 2 words of len=8 -> all outputs 0 asynchronously, no done; new burst afterwards correct.
REQ-037 SHALL test with SRAM_BURST_READER_LAST_EN: len=3 -> out_last high only on third word.
